// File: rtl/sw_key_io_pkg.sv
// sw_key_io_pkg: shared constants, types and helpers for the KEY/SW input device.
// Build option: define KEY_DEBOUNCE_EN to debounce the keys as well as the switches.
package sw_key_io_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned SW_W  = 10;

  localparam logic [BUS_W-1:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [BUS_W-1:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [BUS_W-1:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [BUS_W-1:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int unsigned BIT_READY   = 0;
  localparam int unsigned BIT_OVERRUN = 2;
  localparam int unsigned BIT_IE      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_e;

  // Per-channel control/status bits
  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } status_t;

  // Status update: a commit beats a concurrent read, and a new overrun beats a clearing write
  function automatic status_t status_next(input status_t          cur,
                                          input logic             commit,
                                          input logic             rd,
                                          input logic             wr,
                                          input logic [BUS_W-1:0] wdata);
    status_t nxt;
    nxt = cur;
    if (wr) begin
      nxt.ie = wdata[BIT_IE];
      if (!wdata[BIT_OVERRUN]) begin
        nxt.overrun = 1'b0;
      end
    end
    if (rd) begin
      nxt.ready = 1'b0;
    end
    if (commit) begin
      nxt.ready = 1'b1;
      if (cur.ready && !rd) begin
        nxt.overrun = 1'b1;
      end
    end
    return nxt;
  endfunction

  // Control register read image
  function automatic logic [BUS_W-1:0] ctrl_word(input status_t st);
    logic [BUS_W-1:0] w;
    w              = '0;
    w[BIT_IE]      = st.ie;
    w[BIT_OVERRUN] = st.overrun;
    w[BIT_READY]   = st.ready;
    return w;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: commits a vector once it has held one value for DEBOUNCE_CYCLES
// counted cycles; any change restarts the count, a return to the committed value aborts.
module input_debouncer
  import sw_key_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             commit_c
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: track a candidate value and count how long it has been held
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (din != stable_q) begin
          cand_d  = din;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (din != cand_q) begin
          cand_d = din;
          cnt_d  = '0;
        end else if (cand_q == stable_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = cand_q;
          commit_c = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any count in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/sw_key_io.sv
// sw_key_io: memory-mapped KEY/SW input device with ready/overrun status and an IRQ.
// Build option: define KEY_DEBOUNCE_EN to pass the keys through their own debouncer;
// otherwise a key change commits the cycle after the synchroniser output changes.
module sw_key_io
  import sw_key_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [KEY_W-1:0] KEY,
  input  logic [SW_W-1:0]  SW,
  input  logic [BUS_W-1:0] abus,
  input  logic             re,
  input  logic             we,
  input  logic [BUS_W-1:0] dbus_in,
  output logic [BUS_W-1:0] dbus_out,
  output logic             sel,
  output logic             intr
);

  logic [KEY_W-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [KEY_W-1:0] key_lvl_c;
  logic [KEY_W-1:0] kdata;
  logic             k_commit_c;
  logic [SW_W-1:0]  sdata;
  logic             s_commit_c;
  status_t          k_stat_q, k_stat_d;
  status_t          s_stat_q, s_stat_d;
  logic             intr_q, intr_d;
  logic             rd_kdata_c, rd_sdata_c, wr_kctrl_c, wr_sctrl_c;

  // Keys are active-low on the board; 1 means pressed from here on
  assign key_lvl_c = ~key_s2_q;

`ifdef KEY_DEBOUNCE_EN
  input_debouncer #(
    .WIDTH           (KEY_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .din      (key_lvl_c),
    .stable   (kdata),
    .commit_c (k_commit_c)
  );
`else
  logic [KEY_W-1:0] kdata_q, kdata_d;

  // Undebounced keys commit whenever the synchronised level differs from kdata
  always_comb begin
    k_commit_c = (key_lvl_c != kdata_q);
    kdata_d    = k_commit_c ? key_lvl_c : kdata_q;
  end

  // Key data register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      kdata_q <= '0;
    end else begin
      kdata_q <= kdata_d;
    end
  end

  assign kdata = kdata_q;
`endif

  input_debouncer #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .din      (sw_s2_q),
    .stable   (sdata),
    .commit_c (s_commit_c)
  );

  // Next-state for synchronisers, status bits and interrupt
  always_comb begin
    key_s1_d   = KEY;
    key_s2_d   = key_s1_q;
    sw_s1_d    = SW;
    sw_s2_d    = sw_s1_q;
    rd_kdata_c = re && (abus == ADDR_KDATA);
    rd_sdata_c = re && (abus == ADDR_SDATA);
    wr_kctrl_c = we && (abus == ADDR_KCTRL);
    wr_sctrl_c = we && (abus == ADDR_SCTRL);
    k_stat_d   = status_next(k_stat_q, k_commit_c, rd_kdata_c, wr_kctrl_c, dbus_in);
    s_stat_d   = status_next(s_stat_q, s_commit_c, rd_sdata_c, wr_sctrl_c, dbus_in);
    intr_d     = (k_stat_q.ie && k_stat_q.ready) || (s_stat_q.ie && s_stat_q.ready);
  end

  // Registers; synchronisers reset to the idle pin levels
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      k_stat_q <= '0;
      s_stat_q <= '0;
      intr_q   <= 1'b0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      k_stat_q <= k_stat_d;
      s_stat_q <= s_stat_d;
      intr_q   <= intr_d;
    end
  end

  // Address decode and read mux, combinational from the registers
  always_comb begin
    dbus_out = '0;
    sel      = 1'b0;
    case (abus)
      ADDR_KDATA: begin
        sel      = 1'b1;
        dbus_out = BUS_W'(kdata);
      end
      ADDR_SDATA: begin
        sel      = 1'b1;
        dbus_out = BUS_W'(sdata);
      end
      ADDR_KCTRL: begin
        sel      = 1'b1;
        dbus_out = ctrl_word(k_stat_q);
      end
      ADDR_SCTRL: begin
        sel      = 1'b1;
        dbus_out = ctrl_word(s_stat_q);
      end
      default: begin
        dbus_out = '0;
        sel      = 1'b0;
      end
    endcase
  end

  assign intr = intr_q;

endmodule

// File: tb/tb_sw_key_io.sv
// tb_sw_key_io: directed and random stimulus against a behavioural model of sw_key_io,
// with expected bus/IRQ values queued at issue time and checked by a separate monitor.
module tb_sw_key_io;

  localparam int unsigned N = 4;

  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SDATA = 32'hF000_0014;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;
  localparam logic [31:0] A_NONE  = 32'hF000_0018;

  logic        CLOCK_50;
  logic        RESET;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] abus;
  logic        re;
  logic        we;
  logic [31:0] dbus_in;
  logic [31:0] dbus_out;
  logic        sel;
  logic        intr;

  sw_key_io #(.DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY      (KEY),
    .SW       (SW),
    .abus     (abus),
    .re       (re),
    .we       (we),
    .dbus_in  (dbus_in),
    .dbus_out (dbus_out),
    .sel      (sel),
    .intr     (intr)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        sel;
    logic        intr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (what the registers hold after the latest edge)
  logic [3:0] m_key_s1, m_key_s2, m_kdata;
  logic [9:0] m_sw_s1, m_sw_s2, m_sdata, m_run_val;
  int         m_run_len;
  logic       m_kr, m_ko, m_ki, m_sr, m_so, m_si, m_intr;
`ifdef KEY_DEBOUNCE_EN
  logic [3:0] m_krun_val;
  int         m_krun_len;
`endif

  logic [31:0] addrs [6];

  // Status bits as {ie, overrun, ready}
  function automatic logic [2:0] st_next(input logic [2:0] cur, input logic commit,
                                         input logic rd, input logic wr, input logic [31:0] wd);
    logic ie, ov, rdy;
    ie  = wr ? wd[8] : cur[2];
    ov  = cur[1];
    if (wr && !wd[2]) ov = 1'b0;
    if (commit && cur[0] && !rd) ov = 1'b1;
    rdy = commit ? 1'b1 : (rd ? 1'b0 : cur[0]);
    return {ie, ov, rdy};
  endfunction

  // One clock edge of the model, using the inputs as they stand before the edge
  task automatic model_step();
    logic [3:0] klev;
    logic [9:0] slev;
    logic       kc, sc, nintr;
    if (RESET) begin
      m_key_s1 = 4'hF; m_key_s2 = 4'hF; m_kdata = '0;
      m_sw_s1 = '0; m_sw_s2 = '0; m_sdata = '0;
      m_run_val = '0; m_run_len = 0;
      {m_kr, m_ko, m_ki, m_sr, m_so, m_si, m_intr} = '0;
`ifdef KEY_DEBOUNCE_EN
      m_krun_val = '0; m_krun_len = 0;
`endif
      return;
    end
    klev  = ~m_key_s2;
    slev  = m_sw_s2;
    nintr = (m_ki && m_kr) || (m_si && m_sr);
    // A switch value commits once seen on N+1 consecutive edges and differs from sdata
    if (slev == m_run_val) m_run_len++;
    else begin m_run_val = slev; m_run_len = 1; end
    sc = (m_run_len >= int'(N + 1)) && (m_run_val != m_sdata);
`ifdef KEY_DEBOUNCE_EN
    if (klev == m_krun_val) m_krun_len++;
    else begin m_krun_val = klev; m_krun_len = 1; end
    kc = (m_krun_len >= int'(N + 1)) && (m_krun_val != m_kdata);
`else
    kc = (klev != m_kdata);
`endif
    {m_ki, m_ko, m_kr} = st_next({m_ki, m_ko, m_kr}, kc, re && abus == A_KDATA,
                                 we && abus == A_KCTRL, dbus_in);
    {m_si, m_so, m_sr} = st_next({m_si, m_so, m_sr}, sc, re && abus == A_SDATA,
                                 we && abus == A_SCTRL, dbus_in);
    if (kc) m_kdata = klev;
    if (sc) m_sdata = slev;
    m_intr   = nintr;
    m_key_s2 = m_key_s1; m_key_s1 = KEY;
    m_sw_s2  = m_sw_s1;  m_sw_s1  = SW;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a == A_KDATA) return {28'b0, m_kdata};
    if (a == A_SDATA) return {22'b0, m_sdata};
    if (a == A_KCTRL) return {23'b0, m_ki, 5'b0, m_ko, 1'b0, m_kr};
    if (a == A_SCTRL) return {23'b0, m_si, 5'b0, m_so, 1'b0, m_sr};
    return 32'h0;
  endfunction

  function automatic logic exp_sel(input logic [31:0] a);
    return (a == A_KDATA) || (a == A_KCTRL) || (a == A_SDATA) || (a == A_SCTRL);
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic rst, input logic [3:0] k, input logic [9:0] s,
                        input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    tick();
    RESET = rst; KEY = k; SW = s; re = r; we = w; abus = a; dbus_in = d;
  endtask

  // Cycle whose expected read value comes from the model
  task automatic drive(input logic rst, input logic [3:0] k, input logic [9:0] s,
                       input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    set_in(rst, k, s, r, w, a, d);
    e.addr = a; e.data = exp_read(a); e.sel = exp_sel(a); e.intr = m_intr;
    exp_q.push_back(e);
  endtask

  // Cycle whose expected read value is a hand-derived constant
  task automatic drive_c(input logic [3:0] k, input logic [9:0] s, input logic r,
                         input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] cval);
    exp_t e;
    set_in(1'b0, k, s, r, w, a, d);
    e.addr = a;
`ifdef KEY_DEBOUNCE_EN
    e.data = exp_read(a);
`else
    e.data = cval;
`endif
    e.sel = exp_sel(a); e.intr = m_intr;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) drive(1'b0, KEY, SW, 1'b0, 1'b0, a, 32'h0);
  endtask

  // Monitor: compare the bus and IRQ against the queued expectation mid-cycle
  always @(negedge CLOCK_50) begin
    if (exp_q.size() != 0) begin
      cur_e = exp_q.pop_front();
      n_checks++;
      if (dbus_out !== cur_e.data) begin
        n_fail++;
        $display("FAIL dbus_out @%h: got %h expected %h (t=%0t)", cur_e.addr, dbus_out, cur_e.data, $time);
      end
      n_checks++;
      if (sel !== cur_e.sel) begin
        n_fail++;
        $display("FAIL sel @%h: got %b expected %b (t=%0t)", cur_e.addr, sel, cur_e.sel, $time);
      end
      n_checks++;
      if (intr !== cur_e.intr) begin
        n_fail++;
        $display("FAIL intr: got %b expected %b (t=%0t)", intr, cur_e.intr, $time);
      end
    end
  end

  initial begin
    RESET = 1'b1; KEY = 4'hF; SW = '0; re = 1'b0; we = 1'b0; abus = A_NONE; dbus_in = '0;
    addrs[0] = A_KDATA; addrs[1] = A_KCTRL; addrs[2] = A_SDATA;
    addrs[3] = A_SCTRL; addrs[4] = A_NONE;  addrs[5] = 32'h0000_0010;

    // Reset, then every register reads 0 and unmapped addresses deselect
    drive_c(4'hF, 10'h0, 1'b0, 1'b0, A_KDATA, 32'h0, 32'h0);
    tick(); RESET = 1'b1;
    hold(1, A_KDATA);
    for (int i = 0; i < 6; i++) drive_c(4'hF, 10'h0, 1'b1, 1'b0, addrs[i], 32'h0, 32'h0);

    // Key press: ready within 3 cycles, cleared by the data read
    drive(1'b0, 4'hE, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0);
    hold(2, A_KCTRL);
    drive_c(4'hE, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0, 32'h1);
    drive_c(4'hE, 10'h0, 1'b1, 1'b0, A_KDATA, 32'h0, 32'h1);
    drive_c(4'hE, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0, 32'h0);

    // Release and clear, then two key changes without a read give an overrun
    drive(1'b0, 4'hF, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0);
    hold(2, A_KCTRL);
    drive_c(4'hF, 10'h0, 1'b1, 1'b0, A_KDATA, 32'h0, 32'h0);
    drive_c(4'hF, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0, 32'h0);
    drive(1'b0, 4'hE, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0);
    hold(3, A_KCTRL);
    drive(1'b0, 4'hC, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0);
    hold(2, A_KCTRL);
    drive_c(4'hC, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0, 32'h5);
    drive_c(4'hC, 10'h0, 1'b0, 1'b1, A_KCTRL, 32'h0, 32'h5);
    drive_c(4'hC, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0, 32'h1);
    drive_c(4'hC, 10'h0, 1'b0, 1'b1, A_KCTRL, 32'h4, 32'h1);
    drive_c(4'hC, 10'h0, 1'b0, 1'b0, A_KCTRL, 32'h0, 32'h1);
    drive_c(4'hC, 10'h0, 1'b0, 1'b0, A_KDATA, 32'h0, 32'h3);

    // Switch bounce 0->3FF->0->3FF every 2 cycles, then hold 3FF
    drive(1'b0, 4'hC, 10'h3FF, 1'b0, 1'b0, A_SDATA, 32'h0);
    hold(1, A_SDATA);
    drive(1'b0, 4'hC, 10'h000, 1'b0, 1'b0, A_SDATA, 32'h0);
    hold(1, A_SDATA);
    drive_c(4'hC, 10'h3FF, 1'b0, 1'b0, A_SDATA, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) drive_c(4'hC, 10'h3FF, 1'b0, 1'b0, A_SDATA, 32'h0, 32'h0);
    drive_c(4'hC, 10'h3FF, 1'b0, 1'b0, A_SDATA, 32'h0, 32'h3FF);
    drive_c(4'hC, 10'h3FF, 1'b0, 1'b0, A_SCTRL, 32'h0, 32'h1);

    // Interrupt enable on the switch channel, commit SW=5, read to drop the IRQ
    drive_c(4'hC, 10'h3FF, 1'b1, 1'b0, A_SDATA, 32'h0, 32'h3FF);
    drive(1'b0, 4'hC, 10'h3FF, 1'b0, 1'b1, A_SCTRL, 32'h100);
    drive(1'b0, 4'hC, 10'h005, 1'b0, 1'b0, A_SCTRL, 32'h0);
    hold(6, A_SCTRL);
    drive_c(4'hC, 10'h005, 1'b0, 1'b0, A_SCTRL, 32'h0, 32'h101);
    hold(1, A_SCTRL);
    drive_c(4'hC, 10'h005, 1'b1, 1'b0, A_SDATA, 32'h0, 32'h5);
    hold(3, A_SCTRL);

    // Read KDATA on the very edge a new key value commits
    drive_c(4'hC, 10'h005, 1'b1, 1'b0, A_KDATA, 32'h0, 32'h3);
    drive(1'b0, 4'h6, 10'h005, 1'b0, 1'b0, A_KCTRL, 32'h0);
    hold(1, A_KCTRL);
    drive_c(4'h6, 10'h005, 1'b1, 1'b0, A_KDATA, 32'h0, 32'h3);
    drive_c(4'h6, 10'h005, 1'b0, 1'b0, A_KCTRL, 32'h0, 32'h1);
    drive_c(4'h6, 10'h005, 1'b0, 1'b0, A_KDATA, 32'h0, 32'h9);

    // Reset in the middle of a switch debounce
    drive(1'b0, 4'h6, 10'h2AA, 1'b0, 1'b0, A_SDATA, 32'h0);
    hold(3, A_SDATA);
    drive(1'b1, 4'h6, 10'h2AA, 1'b0, 1'b0, A_SDATA, 32'h0);
    drive(1'b0, 4'h6, 10'h2AA, 1'b0, 1'b0, A_SDATA, 32'h0);
    hold(10, A_SDATA);

    // Random traffic: pin changes, reads, writes (some concurrent), rare resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  k;
      logic [9:0]  s;
      logic        r, w, rs;
      logic [31:0] a, d;
      k  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : KEY;
      s  = ($urandom_range(0, 7) == 0) ? 10'($urandom) : SW;
      r  = ($urandom_range(0, 2) == 0);
      w  = ($urandom_range(0, 5) == 0);
      a  = addrs[$urandom_range(0, 5)];
      d  = $urandom;
      rs = ($urandom_range(0, 499) == 0);
      drive(rs, k, s, r, w, a, d);
    end
    hold(4, A_NONE);

    @(negedge CLOCK_50);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_key_io.md
Name: sw_key_io

Overview:
- Memory-mapped input device that sits directly upstream of the processor core's data bus.
- Takes the raw board KEY and SW pins and synchronises them. Switches are debounced.
- Exposes the KDATA, KCTRL, SDATA and SCTRL registers with ready/overrun status and an interrupt request.
- Replaces direct wiring of KEY/SW into the core.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles an input must hold stable before it is committed (10 ms at 50 MHz).
- ADDR_KDATA, 32'hF0000010: key data register address.
- ADDR_KCTRL, 32'hF0000110: key control/status register address.
- ADDR_SDATA, 32'hF0000014: switch data register address.
- ADDR_SCTRL, 32'hF0000114: switch control/status register address.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- KEY  in  4  raw push-buttons, active-low, asynchronous.
- SW  in  10  raw slide switches, asynchronous.
- abus  in  32  bus address.
- re  in  1  read strobe.
- we  in  1  write strobe.
- dbus_in  in  32  write data.
- dbus_out  out  32  read data; 0 when the address is not decoded.
- sel  out  1  high when abus matches one of the four addresses.
- intr  out  1  interrupt request.

Behaviour:
- Reset: all outputs and state are reset on a CLOCK_50 edge with RESET=1.
  - Registers kdata, sdata, ready/overrun/ie bits, debounce counter and candidate are cleared to 0.
  - Synchroniser flops reset to the idle level: KEY all-1, SW all-0.
  - Reset asserted mid-debounce abandons the count.
- Synchronisation: KEY and SW each pass through a 2-flop synchroniser. Logical key value is ~KEY_sync (1 = pressed).
- Key path:
  - Any cycle where ~KEY_sync differs from kdata: kdata <= ~KEY_sync and k_ready <= 1.
  - If k_ready was already 1 and is not being cleared that cycle, k_overrun <= 1.
- Switch debouncer:
  - States: IDLE and COUNT.
  - IDLE: when SW_sync != sdata, load candidate <= SW_sync, cnt <= 0, go to COUNT.
  - COUNT, SW_sync != candidate: reload candidate, cnt <= 0, stay in COUNT.
  - COUNT, SW_sync == candidate and cnt == DEBOUNCE_CYCLES-1: sdata <= candidate, s_ready <= 1, set s_overrun if s_ready was already set and is not being cleared, go to IDLE.
  - COUNT, candidate == sdata (input bounced back): go to IDLE with no commit.
  - Otherwise cnt++.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Read data, combinational from registers:
  - KDATA = {28'b0, kdata}.
  - SDATA = {22'b0, sdata}.
  - KCTRL / SCTRL = {23'b0, ie, 5'b0, overrun, 1'b0, ready}: bit0 ready, bit2 overrun, bit8 ie.
- Read side effect: at the edge where re=1 and abus=ADDR_KDATA (resp. SDATA), ready <= 0.
  - A new commit in the same cycle wins: ready stays 1, data updates, overrun is NOT set.
- Write to KCTRL/SCTRL (we=1):
  - ie <= dbus_in[8].
  - Overrun is write-0-to-clear: dbus_in[2]=0 clears it, 1 leaves it unchanged.
  - Ready is read-only.
  - A write concurrent with a new overrun event leaves overrun=1.
  - Writes to the data registers are ignored.
- intr = (k_ie & k_ready) | (s_ie & s_ready), registered, so it asserts one cycle after ready.
- re and we both asserted: the write takes effect and the read still returns the pre-edge value.

Optional Feature:
- Macro KEY_DEBOUNCE_EN.
- Defined: the key path uses a second debouncer instance with the same DEBOUNCE_CYCLES. kdata and k_ready update only on a commit.
- Undefined: key commits occur the cycle after the synchroniser output changes, as described above.

Decomposition:
- Package sw_key_io_pkg holds:
  - the four address constants;
  - bit-position constants for ready, overrun and ie;
  - the debouncer state enum {IDLE, COUNT}.
- Sub-module input_debouncer, parameterised by WIDTH and DEBOUNCE_CYCLES.
  - Outputs: stable value and a one-cycle commit pulse.
  - One instance for SW; a second for KEY under KEY_DEBOUNCE_EN.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: RESET=1 for 2 cycles with KEY=4'hF, SW=0 -> all reads return 0, intr=0, sel=0 for unmapped addresses.
- Key event: KEY=4'hE -> KDATA read returns 1 and KCTRL bit0=1 within 3 cycles; after reading KDATA, KCTRL returns 0.
- Key overrun: KEY E then C without a read -> KCTRL=32'h5; write KCTRL=0 -> 32'h1; write KCTRL=32'h4 -> still 32'h1.
- Switch debounce: SW 0->3FF->0->3FF with toggles every 2 cycles, then hold 3FF -> SDATA stays 0 during the bounce and becomes 3FF exactly 4 cycles after the last toggle plus synchroniser delay; SCTRL bit0=1.
- Interrupt: write SCTRL=32'h100, commit SW=5 -> intr rises one cycle after s_ready; reading SDATA drops intr the next cycle.
- Simultaneous read and commit: read KDATA on the exact cycle a new key change commits -> KCTRL=32'h1 (overrun clear) and KDATA shows the new value.
